// File: rtl/keypad_pkg.sv
// Shared constants and FSM state encoding for the keypad debouncer.
package keypad_pkg;

    localparam logic [3:0] NO_KEY   = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } kp_state_t;

endpackage

// File: rtl/keypad_frame_acc.sv
// Collapses one 4-row scan frame into a single key code: the first valid hit in scan order wins.
module keypad_frame_acc
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    input  logic [3:0] key_in,
    input  logic       row_b,
    output logic [3:0] frame_key,
    output logic       frame_done
);

    logic       frame_valid;
    logic       hit;
    logic [3:0] cap;
    logic       cur_hit;

    assign cur_hit = press && (key_in != NO_KEY);

    // The row_b cycle both closes the previous frame and is row 0 of the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            hit         <= 1'b0;
            cap         <= NO_KEY;
            frame_key   <= NO_KEY;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (row_b) begin
                frame_valid <= 1'b1;
                if (frame_valid) begin
                    frame_key  <= cap;
                    frame_done <= 1'b1;
                end
                hit <= cur_hit;
                cap <= cur_hit ? key_in : NO_KEY;
            end else if (!hit && cur_hit) begin
                hit <= 1'b1;
                cap <= key_in;
            end
        end
    end

endmodule

// File: rtl/keypad_debounce.sv
// Frame-based keypad debouncer with valid/ack handshake and interrupt pulse.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    input  logic [3:0] key_in,
    input  logic       row_b,
    input  logic       key_ack,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       intr,
    output logic       overrun
);

    // state       | meaning
    // IDLE        | no key seen
    // PRESS_CHK   | candidate key seen, counting identical frames
    // HELD        | key accepted, waiting for it to change
    // RELEASE_CHK | frames differ from accepted key, counting toward release

    localparam int MAX_FRAMES = (DEBOUNCE_FRAMES > REPEAT_DELAY)
                              ? ((DEBOUNCE_FRAMES > REPEAT_RATE) ? DEBOUNCE_FRAMES : REPEAT_RATE)
                              : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam int CNT_W = $clog2(MAX_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_DB  = CNT_W'(DEBOUNCE_FRAMES);

    logic [3:0]       frame_key;
    logic             frame_done;
    kp_state_t        state, state_n;
    logic [3:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             accept;

    keypad_frame_acc u_frame_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .press      (press),
        .key_in     (key_in),
        .row_b      (row_b),
        .frame_key  (frame_key),
        .frame_done (frame_done)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] CNT_DLY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] CNT_RATE = CNT_W'(REPEAT_RATE);
    logic rep_phase, rep_phase_n;

    // rep_phase is only meaningful inside HELD; any entry into HELD starts from the delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              rep_phase <= 1'b0;
        else if (state != HELD)  rep_phase <= 1'b0;
        else                     rep_phase <= rep_phase_n;
    end
`endif

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_phase_n = rep_phase;
`endif
        if (frame_done) begin
            case (state)
                IDLE: if (frame_key != NO_KEY) begin
                    cand_n = frame_key;
                    if (CNT_ONE == CNT_DB) begin
                        accept  = 1'b1;
                        state_n = HELD;
                        cnt_n   = '0;
                    end else begin
                        state_n = PRESS_CHK;
                        cnt_n   = CNT_ONE;
                    end
                end
                PRESS_CHK: if (frame_key == cand) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_DB) begin
                        accept  = 1'b1;
                        state_n = HELD;
                        cnt_n   = '0;
                    end
                end else if (frame_key == NO_KEY) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cand_n = frame_key;
                    cnt_n  = CNT_ONE;
                end
                HELD: if (frame_key != cand) begin
                    if (CNT_ONE == CNT_DB) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = RELEASE_CHK;
                        cnt_n   = CNT_ONE;
                    end
                end
`ifdef KEYPAD_REPEAT_EN
                else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == (rep_phase ? CNT_RATE : CNT_DLY)) begin
                        accept      = 1'b1;
                        cnt_n       = '0;
                        rep_phase_n = 1'b1;
                    end
                end
`endif
                RELEASE_CHK: if (frame_key == cand) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_DB) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= NO_KEY;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // A same-cycle ack frees the holding register, so the new event takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            intr      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            intr <= 1'b0;
            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= cand;
                    key_valid <= 1'b1;
                    intr      <= 1'b1;
                    overrun   <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_ack && key_valid) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: scanner model with a 4-clk frame, directed scenarios plus random key runs.
module tb_keypad_debounce;

    localparam logic [3:0] NO = 4'd13;
    localparam int DB      = 8;
    localparam int R_DELAY = 64;
    localparam int R_RATE  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       press;
    logic [3:0] key_in;
    logic       row_b;
    logic       key_ack;
    logic [3:0] key_code;
    logic       key_valid;
    logic       intr;
    logic       overrun;

    keypad_debounce #(.DEBOUNCE_FRAMES(DB), .REPEAT_DELAY(R_DELAY), .REPEAT_RATE(R_RATE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .press     (press),
        .key_in    (key_in),
        .row_b     (row_b),
        .key_ack   (key_ack),
        .key_code  (key_code),
        .key_valid (key_valid),
        .intr      (intr),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int intr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: works on the sequence of completed frame keys.
    bit         m_held;
    logic [3:0] m_hkey, m_rkey, m_code;
    int         m_miss, m_run, m_hf;
    bit         m_valid, m_ovr, m_intr;
    bit         have_pending;
    logic [3:0] pending;

    task automatic model_reset();
        m_held = 0; m_hkey = NO; m_rkey = NO; m_code = 4'd0;
        m_miss = 0; m_run = 0; m_hf = 0;
        m_valid = 0; m_ovr = 0; m_intr = 0;
        have_pending = 0; pending = NO;
    endtask

    task automatic model_ack(input bit ack);
        m_intr = 0;
        if (ack && m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    task automatic model_close(input logic [3:0] f, input bit ack);
        bit ev = 0;
        if (m_held) begin
            if (f == m_hkey) begin
                if (m_miss > 0) m_hf = 0;
                else            m_hf++;
                m_miss = 0;
`ifdef KEYPAD_REPEAT_EN
                if (m_hf >= R_DELAY && ((m_hf - R_DELAY) % R_RATE) == 0) ev = 1;
`endif
            end else begin
                m_miss++;
                if (m_miss == DB) begin
                    m_held = 0;
                    m_run  = 0;
                end
            end
        end else begin
            if (f == NO)                         m_run = 0;
            else if (m_run > 0 && f == m_rkey)   m_run++;
            else begin m_rkey = f; m_run = 1; end
            if (m_run == DB) begin
                ev = 1; m_held = 1; m_hkey = m_rkey; m_miss = 0; m_hf = 0; m_run = 0;
            end
        end
        m_intr = 0;
        if (ev) begin
            if (!m_valid || ack) begin
                m_code = m_hkey; m_valid = 1; m_intr = 1; m_ovr = 0;
            end else begin
                m_ovr = 1;
            end
        end else if (ack && m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    task automatic check_outs(input string tag, input bit exp_intr);
        chk({tag, "_valid"}, key_valid, m_valid);
        chk({tag, "_code"},  key_code,  m_code);
        chk({tag, "_ovr"},   overrun,   m_ovr);
        chk({tag, "_intr"},  intr,      exp_intr);
        if (intr === 1'b1) intr_seen++;
    endtask

    // One scan frame: key k appears first at a random row; later rows may carry other hits.
    task automatic run_frame(input logic [3:0] k, input bit ack1, input bit ack3);
        int r = $urandom_range(0, 3);
        for (int c = 0; c < 4; c++) begin
            row_b = (c == 0);
            if (k != NO && c == r) begin
                press = 1'b1; key_in = k;
            end else if (k != NO && c > r) begin
                press = 1'($urandom_range(0, 1)); key_in = 4'($urandom_range(0, 15));
            end else begin
                press = 1'($urandom_range(0, 1));
                key_in = press ? NO : 4'($urandom_range(0, 15));
            end
            key_ack = (c == 1) ? ack1 : (c == 3) ? ack3 : 1'b0;
            if (c == 0 || c == 2) begin
                @(negedge clk);
                check_outs((c == 0) ? "frm_start" : "frm_close", (c == 2) ? m_intr : 1'b0);
            end
            @(posedge clk); #1;
            if (c == 1) begin
                if (have_pending) model_close(pending, ack1);
                else              model_ack(ack1);
            end
            if (c == 3) model_ack(ack3);
        end
        key_ack = 1'b0;
        pending = k;
        have_pending = 1;
    endtask

    task automatic frames(input logic [3:0] k, input int n, input bit ack3);
        for (int i = 0; i < n; i++) run_frame(k, 1'b0, ack3);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; press = 1'b0; key_in = NO; row_b = 1'b0; key_ack = 1'b0;
        model_reset();
        #3;
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_intr", intr, 0);
        chk("rst_ovr", overrun, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: single event for a long hold
        frames(NO, 2, 1'b0);
        base = intr_seen;
        frames(4'd5, 9, 1'b0);
        chk("t1_code", key_code, 5);
        chk("t1_valid", key_valid, 1);
        frames(4'd5, 20, 1'b0);
        chk("t1_one_event", intr_seen - base, 1);

        // 2: a NO_KEY glitch restarts press debounce
        frames(NO, 10, 1'b1);
        base = intr_seen;
        frames(4'd7, 3, 1'b0);
        frames(NO, 1, 1'b0);
        frames(4'd7, 8, 1'b0);
        chk("t2_early", intr_seen - base, 0);
        frames(4'd7, 1, 1'b0);
        chk("t2_event", intr_seen - base, 1);
        chk("t2_code", key_code, 7);

        // 3: overrun when the CPU has not acknowledged
        frames(NO, 10, 1'b1);
        frames(4'd2, 9, 1'b0);
        frames(NO, 8, 1'b0);
        base = intr_seen;
        frames(4'd0, 9, 1'b0);
        chk("t3_code", key_code, 2);
        chk("t3_ovr", overrun, 1);
        chk("t3_no_intr", intr_seen - base, 0);
        run_frame(NO, 1'b0, 1'b1);
        chk("t3_ack_valid", key_valid, 0);
        chk("t3_ack_ovr", overrun, 0);

        // 4: ack in the accept cycle hands the register to the new key
        frames(NO, 10, 1'b1);
        frames(4'd4, 9, 1'b0);
        frames(NO, 9, 1'b0);
        frames(4'd9, 8, 1'b0);
        base = intr_seen;
        run_frame(4'd9, 1'b1, 1'b0);
        chk("t4_intr", intr_seen - base, 1);
        chk("t4_code", key_code, 9);
        chk("t4_valid", key_valid, 1);
        chk("t4_ovr", overrun, 0);

        // 5: async reset in RELEASE_CHK, key still down
        frames(NO, 10, 1'b1);
        frames(4'd3, 9, 1'b0);
        frames(NO, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_code", key_code, 0);
        chk("t5_rst_valid", key_valid, 0);
        chk("t5_rst_ovr", overrun, 0);
        chk("t5_rst_intr", intr, 0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        base = intr_seen;
        frames(4'd3, 8, 1'b0);
        chk("t5_early", intr_seen - base, 0);
        frames(4'd3, 1, 1'b0);
        chk("t5_reaccept", intr_seen - base, 1);
        chk("t5_code", key_code, 3);

`ifdef KEYPAD_REPEAT_EN
        // 6: auto-repeat on a held #
        frames(NO, 10, 1'b1);
        base = intr_seen;
        frames(4'd11, 110, 1'b1);
        chk("t6_events", intr_seen - base, 4);
        chk("t6_code", key_code, 11);
`endif

        // random key runs with random acks
        for (int run = 0; run < 40; run++) begin
            logic [3:0] k;
            int len;
            k   = 4'($urandom_range(0, 13));
            if (k > 4'd11) k = NO;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                run_frame(k, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end
        frames(NO, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
